// File: rtl/lift53_row_seq.sv
// lift53_row_seq: sequences one row of a forward 5/3 lifting transform over a shared sample memory
module lift53_row_seq #(
  parameter int W      = 19,
  parameter int AW     = 10,
  parameter int DP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [W-1:0]  mem_rdata,
  output logic          mem_wr,
  output logic [W-1:0]  mem_wdata,
  output logic          dp_mode,
  output logic [W-1:0]  x2,
  output logic [W-1:0]  x3,
  output logic [W-1:0]  x4,
  input  logic [W-1:0]  dp_d,
  input  logic [W-1:0]  dp_a
);
  localparam int CW = $clog2(DP_LAT + 1);
  typedef enum logic [2:0] {IDLE, RD, CAP, EXE, WR, DONE} state_t;
  state_t        state, nxt;
  logic [1:0]    k;
  logic [CW-1:0] cnt;
  logic [AW:0]   i, n, l_adr, r_adr;
  logic [AW+1:0] i_nxt;
  assign i_nxt = {1'b0, i} + (AW+2)'(2);
  assign l_adr = (i == '0) ? (AW+1)'(1) : i - (AW+1)'(1);
  assign r_adr = (i == n - (AW+1)'(1)) ? i - (AW+1)'(1) : i + (AW+1)'(1);
  // next state and Moore outputs; write data passes the selected datapath result straight through
  always_comb begin
    nxt       = state;
    busy      = state != IDLE;
    done      = state == DONE;
    mem_rd    = state == RD;
    mem_wr    = state == WR;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: nxt = start ? ((len >= (AW+1)'(2)) ? RD : DONE) : IDLE;
      RD: begin
        nxt      = (k == 2'd2) ? CAP : RD;
        mem_addr = AW'((k == 2'd0) ? l_adr : (k == 2'd1) ? i : r_adr);
      end
      CAP: nxt = EXE;
      EXE: nxt = (cnt == CW'(DP_LAT - 1)) ? WR : EXE;
      WR: begin
        nxt       = (i_nxt < {1'b0, n} || !dp_mode) ? RD : DONE;
        mem_addr  = AW'(i);
        mem_wdata = dp_mode ? dp_a : dp_d;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state register, step/pass bookkeeping and registered operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      cnt     <= '0;
      i       <= '0;
      n       <= '0;
      dp_mode <= 1'b0;
      x2      <= '0;
      x3      <= '0;
      x4      <= '0;
    end else begin
      state <= nxt;
      k     <= (state == RD && k != 2'd2) ? k + 2'd1 : 2'd0;
      cnt   <= (state == EXE) ? cnt + CW'(1) : '0;
      if (state == IDLE && start && len >= (AW+1)'(2)) begin
        n       <= len;
        i       <= (AW+1)'(1);
        dp_mode <= 1'b0;
      end
      if (state == RD && k == 2'd1) x2 <= mem_rdata;
      if (state == RD && k == 2'd2) x3 <= mem_rdata;
      if (state == CAP) x4 <= mem_rdata;
      if (state == WR) begin
        if (i_nxt < {1'b0, n}) i <= i_nxt[AW:0];
        else if (!dp_mode) begin
          dp_mode <= 1'b1;
          i       <= '0;
        end
      end
    end
  end
endmodule
